// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types, command codes and byte-swap helper for the AES stream controller
package aes_ctrl_pkg;
  typedef enum logic [1:0] {
    KEY_EXP = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } aes_op_t;
  localparam logic [31:0] CMD_SET_KEY = 32'h0000_0020;
  localparam logic [31:0] CMD_ENCRYPT = 32'h0000_0010;
  localparam logic [31:0] CMD_DECRYPT = 32'h0000_0008;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
  function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_blk_serializer.sv
// aes_blk_serializer: holds one 128-bit result and emits it as 4 stream words
module aes_blk_serializer
  import aes_ctrl_pkg::*;
#(
  parameter int WORD_S     = 32,
  parameter int BLK_S      = 128,
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              last_in,
  input  logic [BLK_S-1:0]  blk_in,
  output logic [WORD_S-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              done
);
  logic [BLK_S-1:0] blk_q, blk_d;
  logic [1:0] idx_q, idx_d;
  logic valid_q, valid_d, last_q, last_d;
  logic [WORD_S-1:0] word;
  always_comb begin
    word = blk_q[idx_q*WORD_S +: WORD_S];
    m_axis_tdata = SWAP_BYTES ? swap_bytes32(word) : word;
    m_axis_tvalid = valid_q;
    m_axis_tlast = valid_q && last_q && idx_q == 2'd3;
    done = valid_q && m_axis_tready && idx_q == 2'd3;
    blk_d = load ? blk_in : blk_q;
    last_d = load ? last_in : last_q;
    valid_d = load || (valid_q && !done);
    idx_d = load ? 2'd0 : (valid_q && m_axis_tready) ? idx_q + 2'd1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      blk_q <= blk_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: parses a command word, packs stream words into AES blocks,
// runs the core one block at a time and streams results back out
module aes_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int WORD_S     = 32,
  parameter int BLK_S      = 128,
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_S-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [WORD_S-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [1:0]        aes_op,
  output logic              aes_start,
  output logic [BLK_S-1:0]  aes_in_blk,
  input  logic [BLK_S-1:0]  aes_out_blk,
  input  logic              aes_done,
  output logic              err,
  output logic [31:0]       blk_cnt
);
  state_t state_q, state_d;
  aes_op_t op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic pkt_last_q, pkt_last_d, err_q, err_d;
  logic [BLK_S-1:0] blk_q, blk_d;
  logic [31:0] cnt_q, cnt_d;
  logic [WORD_S-1:0] word;
  logic xfer, cmd_ok, ser_load, ser_done;
  always_comb begin
    word = SWAP_BYTES ? swap_bytes32(s_axis_tdata) : s_axis_tdata;
    cmd_ok = word == CMD_SET_KEY || word == CMD_ENCRYPT || word == CMD_DECRYPT;
    s_axis_tready = state_q inside {S_IDLE, S_LOAD, S_DRAIN};
    xfer = s_axis_tvalid && s_axis_tready;
    aes_start = state_q == S_START;
    aes_op = op_q;
    aes_in_blk = blk_q;
    err = err_q;
    blk_cnt = cnt_q;
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    pkt_last_d = pkt_last_q;
    blk_d = blk_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    ser_load = 1'b0;
    case (state_q)
      S_IDLE: if (xfer) begin
        op_d = word == CMD_SET_KEY ? KEY_EXP : word == CMD_ENCRYPT ? ENCRYPT : word == CMD_DECRYPT ? DECRYPT : op_q;
        err_d = !cmd_ok;
        idx_d = 2'd0;
        state_d = s_axis_tlast ? S_IDLE : cmd_ok ? S_LOAD : S_DRAIN;
      end
      S_LOAD: if (xfer) begin
        blk_d[idx_q*WORD_S +: WORD_S] = word;
        idx_d = idx_q + 2'd1;
        pkt_last_d = s_axis_tlast;
        // a packet ending mid-block is dropped without touching the core
        err_d = s_axis_tlast && idx_q != 2'd3;
        state_d = idx_q == 2'd3 ? S_START : s_axis_tlast ? S_IDLE : S_LOAD;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: if (aes_done) begin
        ser_load = op_q != KEY_EXP;
        cnt_d = op_q != KEY_EXP ? cnt_q + 32'd1 : cnt_q;
        idx_d = 2'd0;
        state_d = op_q != KEY_EXP ? S_SEND : pkt_last_q ? S_IDLE : S_LOAD;
      end
      S_SEND: if (ser_done) begin
        idx_d = 2'd0;
        state_d = pkt_last_q ? S_IDLE : S_LOAD;
      end
      S_DRAIN: if (xfer && s_axis_tlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= KEY_EXP;
      idx_q <= '0;
      pkt_last_q <= 1'b0;
      blk_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      pkt_last_q <= pkt_last_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  aes_blk_serializer #(
    .WORD_S(WORD_S),
    .BLK_S(BLK_S),
    .SWAP_BYTES(SWAP_BYTES)
  ) u_ser (
    .clk(clk),
    .reset(reset),
    .load(ser_load),
    .last_in(pkt_last_q),
    .blk_in(aes_out_blk),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .done(ser_done)
  );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: directed scenarios against a mock AES core using FIPS-197 vectors
module tb_aes_stream_ctrl;
  localparam logic [127:0] KEY_BLK = 128'h0c0d0e0f_08090a0b_04050607_00010203;
  localparam logic [127:0] PT_BLK  = 128'hccddeeff_8899aabb_44556677_00112233;
  localparam logic [127:0] CT_BLK  = 128'h70b4c55a_d8cdb780_6a7b0430_69c4e0d8;
  localparam logic [127:0] MASK    = {4{32'ha5a5a5a5}};

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0;
  logic s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0] m_axis_tdata, blk_cnt;
  logic [1:0] aes_op;
  logic aes_start, aes_done = 1'b0, err;
  logic [127:0] aes_in_blk, aes_out_blk = '0;

  int vectors = 0, miscompares = 0;
  int tr_mode = 0;
  logic tr_man = 1'b0;
  logic [7:0] pat = '0;
  logic [32:0] rxq[$];
  int starts[4] = '{0, 0, 0, 0};
  int err_cnt = 0, stab_err = 0, core_err = 0;
  int cyc = 0, in_cyc = 0, start_cyc = 0, done_cyc = 0, tv_cyc = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0, prev_start = 1'b0, prev_tv = 1'b0;
  logic [31:0] prev_data = '0;
  int cd = 0;
  logic [127:0] cap_blk = '0, res = '0, key_q = '0;
  logic [1:0] cap_op = '0;

  aes_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .aes_op(aes_op), .aes_start(aes_start), .aes_in_blk(aes_in_blk), .aes_out_blk(aes_out_blk),
    .aes_done(aes_done), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;
  assign m_axis_tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? (pat[2:0] < 3'd6) : tr_man;

  function automatic logic [127:0] core_model(input logic [1:0] op, input logic [127:0] b, input logic [127:0] k);
    if (op == 2'd1) return (k == KEY_BLK && b == PT_BLK) ? CT_BLK : b ^ MASK;
    if (op == 2'd2) return (k == KEY_BLK && b == CT_BLK) ? PT_BLK : b ^ MASK;
    return '0;
  endfunction

  // mock core: result 4 cycles after start; it keeps running through a controller reset
  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        aes_done <= 1'b1;
        aes_out_blk <= res;
        if (aes_in_blk !== cap_blk || aes_op !== cap_op) core_err <= core_err + 1;
      end
    end
    if (aes_start) begin
      cap_blk <= aes_in_blk;
      cap_op <= aes_op;
      cd <= 4;
      res <= core_model(aes_op, aes_in_blk, key_q);
      if (aes_op == 2'd0) key_q <= aes_in_blk;
    end
  end

  always @(posedge clk) begin
    pat <= pat + 8'd1;
    cyc <= cyc + 1;
    if (reset) begin
      prev_stall <= 1'b0;
      prev_start <= 1'b0;
      prev_tv <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) rxq.push_back({m_axis_tlast, m_axis_tdata});
      if (prev_stall && (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last || !m_axis_tvalid)) stab_err <= stab_err + 1;
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_data <= m_axis_tdata;
      prev_last <= m_axis_tlast;
      if (aes_start) starts[aes_op] <= starts[aes_op] + 1;
      if (aes_start && prev_start) stab_err <= stab_err + 1;
      prev_start <= aes_start;
      if (err) err_cnt <= err_cnt + 1;
      if (s_tvalid && s_axis_tready) in_cyc <= cyc;
      if (aes_start) start_cyc <= cyc;
      if (aes_done) done_cyc <= cyc;
      if (m_axis_tvalid && !prev_tv) tv_cyc <= cyc;
      prev_tv <= m_axis_tvalid;
    end
  end

  task automatic send_pkt(input logic [31:0] w[16], input int n);
    logic ok;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      s_tdata = w[i];
      s_tlast = (i == n - 1);
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk);
        #1;
        if (ok) break;
      end
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: word %0d not accepted, tready=%b required 1", i, s_axis_tready);
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int t = 0; t < 400; t++) begin
      if (rxq.size() >= n) break;
      @(negedge clk);
    end
    vectors++;
    if (rxq.size() < n) begin
      miscompares++;
      $display("FAIL rx_timeout: got %0d words required %0d", rxq.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
    if (m_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); end
    if (aes_start !== 1'b0 || err !== 1'b0 || m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL rst_pulses: start=%b err=%b tlast=%b required 0", aes_start, err, m_axis_tlast);
    end
    if (blk_cnt !== 32'h0) begin miscompares++; $display("FAIL rst_blk_cnt: got %h required 0", blk_cnt); end
    if (aes_op !== 2'd0) begin miscompares++; $display("FAIL rst_aes_op: got %h required 0", aes_op); end
    if (aes_in_blk !== 128'h0) begin miscompares++; $display("FAIL rst_in_blk: got %h required 0", aes_in_blk); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_key_encrypt();
    logic [31:0] w[16];
    logic [31:0] ex[4] = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470};
    int b = rxq.size(), k0 = starts[0];
    w = '{0: 32'h20000000, 1: 32'h03020100, 2: 32'h07060504, 3: 32'h0b0a0908, 4: 32'h0f0e0d0c, default: 32'h0};
    send_pkt(w, 5);
    repeat (20) @(negedge clk);
    vectors += 2;
    if (starts[0] - k0 !== 1) begin miscompares++; $display("FAIL key_starts: got %0d required 1", starts[0] - k0); end
    if (rxq.size() !== b) begin miscompares++; $display("FAIL key_no_output: got %0d words required 0", rxq.size() - b); end
    w = '{0: 32'h10000000, 1: 32'h33221100, 2: 32'h77665544, 3: 32'hbbaa9988, 4: 32'hffeeddcc, default: 32'h0};
    send_pkt(w, 5);
    wait_rx(b + 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rxq.size() > b + i && rxq[b + i] !== {i == 3, ex[i]}) begin
        miscompares++; $display("FAIL enc_word%0d: got %h required %h", i, rxq[b + i], {i == 3, ex[i]});
      end
    end
    @(negedge clk);
    vectors += 3;
    if (blk_cnt !== 32'd1) begin miscompares++; $display("FAIL enc_blk_cnt: got %0d required 1", blk_cnt); end
    if (start_cyc !== in_cyc + 1) begin miscompares++; $display("FAIL start_latency: got %0d required %0d", start_cyc, in_cyc + 1); end
    if (tv_cyc !== done_cyc + 1) begin miscompares++; $display("FAIL out_latency: got %0d required %0d", tv_cyc, done_cyc + 1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[16];
    logic [31:0] ex[12];
    int b = rxq.size();
    ex = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470,
           32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5,
           32'h5a5a5a5a, 32'h5a5a5a5a, 32'h5a5a5a5a, 32'h5a5a5a5a};
    w = '{0: 32'h10000000, 1: 32'h33221100, 2: 32'h77665544, 3: 32'hbbaa9988, 4: 32'hffeeddcc,
          9: 32'hffffffff, 10: 32'hffffffff, 11: 32'hffffffff, 12: 32'hffffffff, default: 32'h0};
    tr_mode = 1;
    send_pkt(w, 13);
    wait_rx(b + 12);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (rxq.size() > b + i && rxq[b + i] !== {i == 11, ex[i]}) begin
        miscompares++; $display("FAIL multi_word%0d: got %h required %h", i, rxq[b + i], {i == 11, ex[i]});
      end
    end
    @(negedge clk);
    tr_mode = 0;
    vectors += 3;
    if (blk_cnt !== 32'd4) begin miscompares++; $display("FAIL multi_blk_cnt: got %0d required 4", blk_cnt); end
    if (stab_err !== 0) begin miscompares++; $display("FAIL stall_stability: got %0d violations required 0", stab_err); end
    if (core_err !== 0) begin miscompares++; $display("FAIL core_inputs_stable: got %0d violations required 0", core_err); end
  endtask

  task automatic test_decrypt();
    logic [31:0] w[16];
    logic [31:0] ex[4] = '{32'h33221100, 32'h77665544, 32'hbbaa9988, 32'hffeeddcc};
    int b = rxq.size(), d0 = starts[2];
    w = '{0: 32'h08000000, 1: 32'hd8e0c469, 2: 32'h30047b6a, 3: 32'h80b7cdd8, 4: 32'h5ac5b470, default: 32'h0};
    send_pkt(w, 5);
    wait_rx(b + 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rxq.size() > b + i && rxq[b + i] !== {i == 3, ex[i]}) begin
        miscompares++; $display("FAIL dec_word%0d: got %h required %h", i, rxq[b + i], {i == 3, ex[i]});
      end
    end
    @(negedge clk);
    vectors += 2;
    if (starts[2] - d0 !== 1) begin miscompares++; $display("FAIL dec_op: got %0d decrypt starts required 1", starts[2] - d0); end
    if (blk_cnt !== 32'd5) begin miscompares++; $display("FAIL dec_blk_cnt: got %0d required 5", blk_cnt); end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] w[16];
    int b = rxq.size(), e0 = err_cnt, s0 = starts[0] + starts[1] + starts[2] + starts[3];
    w = '{0: 32'h55000000, 1: 32'h10000000, 2: 32'h11111111, 3: 32'h22222222, 4: 32'h33333333, default: 32'h0};
    send_pkt(w, 5);
    repeat (20) @(negedge clk);
    vectors += 4;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL bad_err: got %0d pulses required 1", err_cnt - e0); end
    if (starts[0] + starts[1] + starts[2] + starts[3] - s0 !== 0) begin
      miscompares++; $display("FAIL bad_no_start: got %0d starts required 0", starts[0] + starts[1] + starts[2] + starts[3] - s0);
    end
    if (rxq.size() !== b) begin miscompares++; $display("FAIL bad_no_output: got %0d words required 0", rxq.size() - b); end
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL bad_idle: tready got %b required 1", s_axis_tready); end
  endtask

  task automatic test_short_pkt();
    logic [31:0] w[16];
    logic [31:0] ex[4] = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470};
    int b, e0 = err_cnt, s0 = starts[1];
    w = '{0: 32'h10000000, 1: 32'h33221100, 2: 32'h77665544, default: 32'h0};
    send_pkt(w, 3);
    repeat (20) @(negedge clk);
    vectors += 2;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL short_err: got %0d pulses required 1", err_cnt - e0); end
    if (starts[1] - s0 !== 0) begin miscompares++; $display("FAIL short_no_start: got %0d starts required 0", starts[1] - s0); end
    b = rxq.size();
    w = '{0: 32'h10000000, 1: 32'h33221100, 2: 32'h77665544, 3: 32'hbbaa9988, 4: 32'hffeeddcc, default: 32'h0};
    send_pkt(w, 5);
    wait_rx(b + 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rxq.size() > b + i && rxq[b + i] !== {i == 3, ex[i]}) begin
        miscompares++; $display("FAIL short_recover_word%0d: got %h required %h", i, rxq[b + i], {i == 3, ex[i]});
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [31:0] w[16];
    logic [31:0] ex[4] = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470};
    int b;
    tr_man = 1'b0;
    tr_mode = 2;
    w = '{0: 32'h10000000, 1: 32'h33221100, 2: 32'h77665544, 3: 32'hbbaa9988, 4: 32'hffeeddcc, default: 32'h0};
    send_pkt(w, 5);
    for (int t = 0; t < 100 && !m_axis_tvalid; t++) @(negedge clk);
    vectors++;
    if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL mid_tvalid_timeout: got %b required 1", m_axis_tvalid); end
    tr_man = 1'b1;
    @(negedge clk);
    tr_man = 1'b0;
    vectors++;
    if (m_axis_tdata !== ex[1]) begin miscompares++; $display("FAIL mid_idx1_word: got %h required %h", m_axis_tdata, ex[1]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors += 2;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_tvalid: got %b required 0", m_axis_tvalid); end
    if (blk_cnt !== 32'd0) begin miscompares++; $display("FAIL mid_rst_blk_cnt: got %0d required 0", blk_cnt); end
    tr_mode = 0;
    @(negedge clk);
    b = rxq.size();
    send_pkt(w, 5);
    wait_rx(b + 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rxq.size() > b + i && rxq[b + i] !== {i == 3, ex[i]}) begin
        miscompares++; $display("FAIL post_rst_word%0d: got %h required %h", i, rxq[b + i], {i == 3, ex[i]});
      end
    end
    @(negedge clk);
    vectors++;
    if (blk_cnt !== 32'd1) begin miscompares++; $display("FAIL post_rst_blk_cnt: got %0d required 1", blk_cnt); end
  endtask

  initial begin
    test_reset();
    test_key_encrypt();
    test_back_to_back();
    test_decrypt();
    test_bad_cmd();
    test_short_pkt();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
Command sequencer between the AXI4-Stream DMA path and the AES core. It parses a command word at the head of each packet. It then assembles 32-bit stream words into 128-bit blocks, starts the core for key expansion, encryption or decryption, and serializes the 128-bit results back onto the master stream with correct TLAST. It owns all byte-order conversion between the little-endian kernel word view and the core's big-endian block view.

Parameters:
WORD_S, 32, stream word width in bits
BLK_S, 128, AES block width in bits
SWAP_BYTES, 1, 1 = byte-reverse each 32-bit word on input and output; 0 = pass through

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  32  input stream word
s_axis_tvalid  in  1  input word valid
s_axis_tready  out  1  controller accepts word
s_axis_tlast  in  1  last word of input packet
m_axis_tdata  out  32  output stream word
m_axis_tvalid  out  1  output word valid
m_axis_tready  in  1  downstream accepts word
m_axis_tlast  out  1  last word of output packet
aes_op  out  2  core operation: 0 = KEY_EXP, 1 = ENCRYPT, 2 = DECRYPT
aes_start  out  1  one-cycle start pulse to core
aes_in_blk  out  128  block to core; bits [0:127], word i at [i*32 +: 32]
aes_out_blk  in  128  core result, same layout
aes_done  in  1  one-cycle core completion pulse
err  out  1  one-cycle pulse on protocol error
blk_cnt  out  32  count of completed ENCRYPT/DECRYPT blocks since reset; wraps at 2^32

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; word index 0; key_only flag 0.
- Command word: the first word of a packet, after the optional byte swap.
  - 0x00000020 = SET_KEY.
  - 0x00000010 = ENCRYPT.
  - 0x00000008 = DECRYPT.
  - Any other value is an error.
- Input transfer: a word transfers when s_axis_tvalid && s_axis_tready.
- s_axis_tready is 1 only in IDLE, LOAD and DRAIN.
- State IDLE:
  - Accept the command word and latch aes_op.
  - tlast=1 on the command word: stay in IDLE, no core activity, no output.
  - Unknown command: pulse err; go to DRAIN, or stay in IDLE if tlast=1.
  - Otherwise go to LOAD with index 0.
- State LOAD:
  - Store the word at aes_in_blk[idx*32 +: 32]; word 0 is the first received.
  - On idx==3, go to START and latch pkt_last = tlast.
  - tlast with idx<3: discard the partial block, pulse err, go to IDLE.
- State START:
  - aes_start=1 for exactly one cycle, then go to WAIT.
  - aes_in_blk and aes_op stay stable from START until aes_done.
- State WAIT:
  - On aes_done, latch aes_out_blk into the output register.
  - SET_KEY: no output. Go to IDLE if pkt_last, else LOAD; a later block reloads the key and the last one wins.
  - ENCRYPT/DECRYPT: increment blk_cnt and go to SEND with index 0.
- State SEND:
  - m_axis_tdata = optional swap of out_reg[idx*32 +: 32], with m_axis_tvalid=1.
  - m_axis_tlast=1 only on idx==3 && pkt_last.
  - Advance idx on m_axis_tready. After idx 3 goes out, go to IDLE if pkt_last, else LOAD.
  - While tvalid && !tready, tdata and tlast hold stable.
- State DRAIN: accept and discard words until tlast, then go to IDLE.
- Latency:
  - 4th data word accepted at cycle N → aes_start at N+1.
  - aes_done at cycle D → first m_axis_tvalid at D+1.
  - With tready held high, the 4 output words go out on D+1..D+4.
- No input/output overlap: the input stalls through START, WAIT and SEND, so there is one block in flight.
- aes_done outside WAIT is ignored.
- Mid-operation reset: return to IDLE next cycle and drop tvalid immediately. A core already running is ignored, because its aes_done arrives outside WAIT.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - typedef aes_op_t (KEY_EXP, ENCRYPT, DECRYPT);
  - the command constants CMD_SET_KEY, CMD_ENCRYPT and CMD_DECRYPT;
  - the state enum;
  - the function swap_bytes32.
- WORD_S and BLK_S come from aes.vh.
- One natural sub-module, aes_blk_serializer: the 128-bit to 4×32 output register with its ready/valid handshake. The FSM, packer and command decode stay in aes_stream_ctrl.

Test Plan:
- Key and encrypt, tready always high:
  - Packet 1: SET_KEY with key 000102030405060708090a0b0c0d0e0f, sent as words 0x03020100, 0x07060504, 0x0b0a0908, 0x0f0e0d0c with tlast on the final word. Expect no output and one aes_op=0 start.
  - Packet 2: ENCRYPT with plaintext 00112233445566778899aabbccddeeff, first word 0x33221100.
  - Expect output words 0xd8e0c469, 0x30047b6a, 0x80b7cdd8, 0x5ac5b470, with tlast on the 4th, and blk_cnt=1.
- Multi-block ENCRYPT, 3 blocks in one packet, with slave tready oscillating 6 high / 2 low: expect 12 output words in order, tlast only on word 12, and data stable across every stall.
- DECRYPT of 69c4e0d86a7b0430d8cdb78070b4c55a with the same key: expect words 0x33221100, 0x77665544, 0xbbaa9988, 0xffeeddcc.
- Command 0x00000055 followed by 4 words, tlast on the last: expect err pulse once, all words accepted, no aes_start, back to IDLE.
- ENCRYPT with tlast on the 2nd data word: expect err pulse, no aes_start. A following valid packet then produces correct output.
- Reset asserted during SEND at idx 1: expect m_axis_tvalid=0 on the next cycle and blk_cnt=0. A fresh ENCRYPT packet then produces the correct 4 words.
